// File: rtl/hwpe_stream_addressgen_v5_pkg.sv
// Shared types for the N-dimensional streaming address generator:
// per-dimension stride config, run control and status flags.
package hwpe_stream_addressgen_v5_pkg;

    localparam int HWPE_STREAM_ADDRESSGEN_V5_MAX_DIMS = 8;

    typedef struct packed {
        logic               enable;
        logic [31:0]        len;
        logic signed [32:0] stride;
    } stride_addressgen_v4_t;

    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] tot_len;
    } ctrl_addressgen_v5_t;

    typedef struct packed {
        logic done;
        logic busy;
    } flags_addressgen_v5_t;

endpackage

// File: rtl/hwpe_stream_addressgen_v5_dimcnt.sv
// One loop-dimension counter: wraps to zero or increments, and reports
// when it sits on the last iteration of its (effective) length.
module hwpe_stream_addressgen_v5_dimcnt
    import hwpe_stream_addressgen_v5_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 inc_i,
    input  logic                 wrap_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    output logic                 is_last_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wrap_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_last_o = (cnt_q == len_i - CNT_WIDTH'(1));

endmodule

// File: rtl/hwpe_stream_addressgen_v5.sv
// N-dimensional address generator: walks NB_DIMS nested loops with jump
// strides and emits one address per valid/ready handshake.
module hwpe_stream_addressgen_v5
    import hwpe_stream_addressgen_v5_pkg::*;
#(
    parameter int NB_DIMS    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              start_i,
    input  ctrl_addressgen_v5_t               ctrl_i,
    input  stride_addressgen_v4_t [NB_DIMS-1:0] stride_i,
    output logic [ADDR_WIDTH-1:0]             addr_o,
    output logic                              addr_valid_o,
    input  logic                              addr_ready_i,
    output logic [NB_DIMS-1:0]                dim_last_o,
    output flags_addressgen_v5_t              flags_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0]  tot_q, tot_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;

    logic [CNT_WIDTH-1:0]  len_in [NB_DIMS];
    logic [CNT_WIDTH-1:0]  len_q  [NB_DIMS];
    logic [32:0]           stride_q [NB_DIMS];

    logic [NB_DIMS-1:0]    is_last;
    logic [NB_DIMS-1:0]    inc_sel, wrap_sel;
    logic [NB_DIMS-1:0]    cnt_inc, cnt_wrap;
    logic                  step_found;
    logic [32:0]           step_stride;

    logic start_ok, handshake, last_issue, advance;

    assign start_ok   = start_i && (state_q != ST_RUN);
    assign handshake  = addr_valid_o && addr_ready_i;
    assign last_issue = (issued_q + CNT_WIDTH'(1) == tot_q);
    assign advance    = handshake && !last_issue && !clear_i;

    // Innermost dimension that still has iterations left takes the step;
    // every dimension below it wraps. If none is left, all wrap.
    always_comb begin
        step_found  = 1'b0;
        step_stride = '0;
        inc_sel     = '0;
        wrap_sel    = '0;
        for (int d = 0; d < NB_DIMS; d++) begin
            if (!step_found) begin
                if (!is_last[d]) begin
                    inc_sel[d]  = 1'b1;
                    step_found  = 1'b1;
                    step_stride = stride_q[d];
                end else begin
                    wrap_sel[d] = 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB_DIMS; gi++) begin : g_dim
            // Dim 0 is always active; its enable bit has no effect.
            assign len_in[gi] = ((stride_i[gi].enable || (gi == 0)) && (stride_i[gi].len != '0))
                              ? CNT_WIDTH'(stride_i[gi].len) : CNT_WIDTH'(1);

            always_ff @(posedge clk_i) begin
                if (rst_i || clear_i) begin
                    len_q[gi]    <= '0;
                    stride_q[gi] <= '0;
                end else if (start_ok) begin
                    len_q[gi]    <= len_in[gi];
                    stride_q[gi] <= stride_i[gi].stride;
                end
            end

            assign cnt_inc[gi]  = advance && inc_sel[gi];
            assign cnt_wrap[gi] = start_ok || (advance && wrap_sel[gi]);

            hwpe_stream_addressgen_v5_dimcnt #(
                .CNT_WIDTH (CNT_WIDTH)
            ) i_dimcnt (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .clear_i   (clear_i),
                .inc_i     (cnt_inc[gi]),
                .wrap_i    (cnt_wrap[gi]),
                .len_i     (len_q[gi]),
                .is_last_o (is_last[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        base_d   = base_q;
        tot_d    = tot_q;
        issued_d = issued_q;
        if (start_ok) begin
            base_d   = ADDR_WIDTH'(ctrl_i.base_addr);
            addr_d   = ADDR_WIDTH'(ctrl_i.base_addr);
            tot_d    = CNT_WIDTH'(ctrl_i.tot_len);
            issued_d = '0;
            state_d  = (ctrl_i.tot_len == '0) ? ST_DONE : ST_RUN;
        end else if (handshake) begin
            issued_d = issued_q + CNT_WIDTH'(1);
            if (last_issue) begin
                state_d = ST_DONE;
            end else if (step_found) begin
                addr_d = addr_q + ADDR_WIDTH'(step_stride);
            end else begin
                addr_d = base_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            base_q   <= '0;
            tot_q    <= '0;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            tot_q    <= tot_d;
            issued_q <= issued_d;
        end
    end

    assign addr_o        = addr_q;
    assign addr_valid_o  = (state_q == ST_RUN);
    assign dim_last_o    = addr_valid_o ? is_last : '0;
    assign flags_o.done  = (state_q == ST_DONE);
    assign flags_o.busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_hwpe_stream_addressgen_v5.sv
// Randomised scoreboard bench: a closed-form address model fills the
// expected queue at start; a negedge monitor pops on every handshake.
module tb_hwpe_stream_addressgen_v5;
    import hwpe_stream_addressgen_v5_pkg::*;

    localparam int NB_DIMS    = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int CNT_WIDTH  = 32;

    logic clk = 1'b0;
    logic rst, clear, start, ready;
    logic valid;
    ctrl_addressgen_v5_t                 ctrl;
    stride_addressgen_v4_t [NB_DIMS-1:0] stride;
    logic [ADDR_WIDTH-1:0]               addr;
    logic [NB_DIMS-1:0]                  dim_last;
    flags_addressgen_v5_t                flags;

    always #5 clk = ~clk;

    hwpe_stream_addressgen_v5 #(
        .NB_DIMS    (NB_DIMS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .start_i      (start),
        .ctrl_i       (ctrl),
        .stride_i     (stride),
        .addr_o       (addr),
        .addr_valid_o (valid),
        .addr_ready_i (ready),
        .dim_last_o   (dim_last),
        .flags_o      (flags)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]        exp_addr_q [$];
    logic [NB_DIMS-1:0] exp_last_q [$];

    logic [31:0] cfg_base;
    int unsigned cfg_tot;
    int unsigned cfg_len [NB_DIMS];
    bit          cfg_en  [NB_DIMS];
    logic [32:0] cfg_str [NB_DIMS];

    int ready_mode = 0;
    int ready_phase = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closed form: position weight of dim d is its jump stride plus the
    // distance the inner loops travelled to reach their last iteration.
    task automatic push_model();
        longint L [NB_DIMS];
        longint P [NB_DIMS];
        longint prod = 1;
        for (int d = 0; d < NB_DIMS; d++) begin
            L[d] = ((d == 0 || cfg_en[d]) && cfg_len[d] != 0) ? longint'(cfg_len[d]) : 1;
            prod = prod * L[d];
        end
        for (int d = 0; d < NB_DIMS; d++) begin
            P[d] = longint'($signed(cfg_str[d]));
            for (int e = 0; e < d; e++) P[d] = P[d] + (L[e] - 1) * P[e];
        end
        for (int i = 0; i < int'(cfg_tot); i++) begin
            longint k;
            longint a;
            longint c;
            logic [NB_DIMS-1:0] lst;
            k   = longint'(i) % prod;
            a   = longint'(cfg_base);
            lst = '0;
            for (int d = 0; d < NB_DIMS; d++) begin
                c = k % L[d];
                k = k / L[d];
                a = a + c * P[d];
                lst[d] = (c == L[d] - 1);
            end
            exp_addr_q.push_back(a[31:0]);
            exp_last_q.push_back(lst);
        end
    endtask

    task automatic clear_dims(logic [31:0] base, int unsigned tot);
        cfg_base = base;
        cfg_tot  = tot;
        for (int d = 0; d < NB_DIMS; d++) begin
            cfg_len[d] = 0;
            cfg_en[d]  = 1'b0;
            cfg_str[d] = '0;
        end
    endtask

    task automatic scramble_inputs();
        ctrl.base_addr = $urandom();
        ctrl.tot_len   = $urandom_range(1, 50);
        for (int d = 0; d < NB_DIMS; d++) begin
            stride[d].enable = 1'($urandom_range(0, 1));
            stride[d].len    = $urandom_range(0, 7);
            stride[d].stride = {1'($urandom_range(0, 1)), $urandom()};
        end
    endtask

    task automatic start_run();
        tick();
        ctrl.base_addr = cfg_base;
        ctrl.tot_len   = cfg_tot;
        for (int d = 0; d < NB_DIMS; d++) begin
            stride[d].enable = cfg_en[d];
            stride[d].len    = cfg_len[d];
            stride[d].stride = cfg_str[d];
        end
        push_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_inputs();
        @(negedge clk);
        check("start_latency", {61'd0, flags.done, flags.busy, valid},
              (cfg_tot == 0) ? 64'b100 : 64'b011);
    endtask

    task automatic wait_done(string name);
        int cyc = 0;
        while (!flags.done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_done"}, 64'(flags.done), 64'd1);
        check({name, "_drained"}, 64'(exp_addr_q.size()), 64'd0);
        exp_addr_q.delete();
        exp_last_q.delete();
    endtask

    // Ready driver: 0 = always, 1 = pattern 1,0,0, 2 = random.
    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: ready = 1'b1;
                1: begin
                    ready = (ready_phase == 0);
                    ready_phase = (ready_phase + 1) % 3;
                end
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic               hold_chk = 1'b0;
    logic               expect_done = 1'b0;
    logic [31:0]        prev_addr;
    logic [NB_DIMS-1:0] prev_last;

    always @(negedge clk) begin
        if (rst || clear) begin
            hold_chk    = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (expect_done) begin
                check("done_after_last", {61'd0, flags.done, flags.busy, valid}, 64'b100);
                expect_done = 1'b0;
            end
            if (hold_chk) begin
                check("hold_valid", 64'(valid), 64'd1);
                check("hold_addr", 64'(addr), 64'(prev_addr));
                check("hold_last", 64'(dim_last), 64'(prev_last));
            end
            hold_chk  = valid && !ready;
            prev_addr = addr;
            prev_last = dim_last;
            if (valid && ready) begin
                if (exp_addr_q.size() == 0) begin
                    check("spurious_addr", 64'(addr), 64'hDEAD_0000_0000_0000);
                end else begin
                    logic [31:0]        ea;
                    logic [NB_DIMS-1:0] el;
                    ea = exp_addr_q.pop_front();
                    el = exp_last_q.pop_front();
                    check("addr", 64'(addr), 64'(ea));
                    check("dim_last", 64'(dim_last), 64'(el));
                    if (exp_addr_q.size() == 0) expect_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        start = 1'b0;
        ctrl  = '0;
        stride = '0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_state", {flags.done, flags.busy, valid, dim_last, addr},
              {2'b00, 1'b0, {NB_DIMS{1'b0}}, {ADDR_WIDTH{1'b0}}});
        tick();
        rst = 1'b0;

        // 1-D
        ready_mode = 0;
        clear_dims(32'h100, 4);
        cfg_len[0] = 4; cfg_str[0] = 33'd4;
        start_run();
        wait_done("1d");

        // 2-D jump, full throughput then backpressure
        for (int m = 0; m < 2; m++) begin
            ready_mode = m;
            clear_dims(32'h0, 6);
            cfg_len[0] = 3; cfg_str[0] = 33'h4;
            cfg_en[1]  = 1'b1; cfg_len[1] = 2; cfg_str[1] = 33'h10;
            start_run();
            wait_done(m == 0 ? "2d" : "2d_bp");
        end

        // tot_len = 0 and repeat-from-base
        ready_mode = 0;
        clear_dims(32'h100, 0);
        cfg_len[0] = 3; cfg_str[0] = 33'd4;
        start_run();
        repeat (3) begin
            @(negedge clk);
            check("zero_len_no_valid", 64'(valid), 64'd0);
        end
        wait_done("zero_len");
        clear_dims(32'h100, 5);
        cfg_len[0] = 3; cfg_str[0] = 33'd4;
        start_run();
        wait_done("repeat");

        // Negative stride with address wrap
        clear_dims(32'h4, 3);
        cfg_len[0] = 3; cfg_str[0] = -33'sd8;
        start_run();
        wait_done("neg_stride");

        // Clear together with the handshake of the 2nd address
        clear_dims(32'h0, 6);
        cfg_len[0] = 3; cfg_str[0] = 33'h4;
        cfg_en[1]  = 1'b1; cfg_len[1] = 2; cfg_str[1] = 33'h10;
        start_run();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("after_clear", {flags.done, flags.busy, valid, dim_last, addr},
              {2'b00, 1'b0, {NB_DIMS{1'b0}}, {ADDR_WIDTH{1'b0}}});
        exp_addr_q.delete();
        exp_last_q.delete();
        start_run();
        wait_done("restart");

        // start_i pulsed while running is ignored
        ready_mode = 1;
        start_run();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("start_in_run");

        // Randomised configurations
        ready_mode = 2;
        for (int r = 0; r < 25; r++) begin
            clear_dims($urandom(), $urandom_range(0, 30));
            for (int d = 0; d < NB_DIMS; d++) begin
                cfg_len[d] = $urandom_range(0, 4);
                cfg_en[d]  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1)
                    cfg_str[d] = {1'($urandom_range(0, 1)), $urandom()};
                else
                    cfg_str[d] = 33'($signed(8'($urandom_range(0, 255))));
            end
            start_run();
            wait_done("random");
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_addressgen_v5.md
Name: hwpe_stream_addressgen_v5

Overview:
- N-dimensional streaming address generator; parametrised successor of the fixed 3-D v3 and the v4 address generators.
- Walks NB_DIMS nested loops, each with its own length, signed jump stride and enable.
- Emits one address per valid/ready handshake toward a source/sink TCDM front-end.
- Sits between the engine's register-file control and hwpe_stream_source/sink request logic.

Parameters:
- NB_DIMS, 4: number of loop dimensions; 1..8; dim 0 is innermost.
- ADDR_WIDTH, 32: emitted address width; 1..32; internal arithmetic is modulo 2^ADDR_WIDTH.
- CNT_WIDTH, 32: width of the per-dimension counters and the total counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- start_i  in  1  one-cycle pulse; samples configuration; accepted in IDLE or DONE only.
- ctrl_i  in  $bits(ctrl_addressgen_v5_t)  base_addr, tot_len.
- stride_i  in  NB_DIMS x $bits(stride_addressgen_v4_t)  per-dim {enable, len, stride}.
- addr_o  out  ADDR_WIDTH  current address.
- addr_valid_o  out  1  addr_o is valid.
- addr_ready_i  in  1  consumer accepts addr_o.
- dim_last_o  out  NB_DIMS  bit d set when counter d is at its last value for the current address.
- flags_o  out  $bits(flags_addressgen_v5_t)  {done, busy}.

Behaviour:
- Clock, reset and handshake:
  - One clock domain: clk_i.
  - Reset is synchronous and active-high on rst_i.
  - A handshake is addr_valid_o & addr_ready_i.
- Reset / clear:
  - State goes to IDLE; all counters 0.
  - addr_o=0, addr_valid_o=0, dim_last_o=0, done=0, busy=0.
  - clear_i has priority over start_i and over a handshake in the same cycle.
  - Clear mid-run drops the pending address; nothing further is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE -> RUN on start_i:
  - Latch ctrl_i and stride_i into shadow registers; later changes on the inputs are ignored.
  - addr <= base_addr; all counters <= 0.
  - addr_valid_o=1 in the next cycle (latency 1); busy=1, done=0.
- IDLE/DONE -> DONE directly if start_i arrives with tot_len==0: done=1, no address is emitted.
- start_i while in RUN is ignored.
- Effective length per dimension:
  - effective len = (enable && len!=0) ? len : 1.
  - Dim 0 is always enabled; its enable bit is ignored.
- In RUN, on each handshake:
  - issued++.
  - If issued+1 == tot_len: go to DONE; addr_valid_o=0, busy=0, done=1 (level, held until start_i or clear).
  - Otherwise, find the lowest d whose counter is not at effective len-1.
    - Counter d increments; all counters below d go to 0.
    - addr <= addr + sext(stride[d]), truncated to ADDR_WIDTH.
    - Strides are jump strides: software precomputes them relative to the last address of the inner loops.
  - If no such d exists (all dims at last): all counters go to 0 and addr <= base_addr (repeat pattern until tot_len is reached).
- Without a handshake, addr_o, addr_valid_o and dim_last_o are stable (valid never drops without ready).
- dim_last_o[d] = (counter d == effective len-1); it is combinational from the counters and is 0 outside RUN.
- Arithmetic:
  - Stride is 33-bit signed and sign-extended before the add.
  - Address wraps modulo 2^ADDR_WIDTH with no error flag.
  - Counters compare against len-1 with unsigned CNT_WIDTH arithmetic.
- Throughput: one address per cycle under continuous ready. The next address is computed from registered state with no combinational path from addr_ready_i to addr_o.

Decomposition:
- hwpe_stream_package gains:
  - ctrl_addressgen_v5_t {base_addr[31:0], tot_len[31:0]}.
  - flags_addressgen_v5_t {done, busy}.
  - HWPE_STREAM_ADDRESSGEN_V5_MAX_DIMS = 8.
- stride_addressgen_v4_t is reused unchanged for the per-dimension configuration.
- The FSM state enum is local to the module.
- One sub-module: hwpe_stream_addressgen_v5_dimcnt.
  - Per-dimension counter: inputs inc/wrap, len; outputs is_last.
  - Instantiated NB_DIMS times via generate.

Test Plan:
- 1-D: base=0x100, tot_len=4, d0 len=4 stride=4, ready=1 -> addresses 0x100, 0x104, 0x108, 0x10C on consecutive cycles; done=1 the cycle after the 4th handshake.
- 2-D jump: base=0, tot_len=6, d0 len=3 stride=4, d1 en len=2 stride=0x10 -> 0x0, 0x4, 0x8, 0x18, 0x1C, 0x20; dim_last_o=2'b01 on 0x8 and 2'b11 on 0x20.
- Backpressure: the 2-D case with ready toggling 1,0,0,1,... -> addr_o and dim_last_o held while ready=0; same 6-address sequence; no duplicates or drops.
- tot_len=0 -> no addr_valid_o ever; done=1 one cycle after start_i. tot_len=5 with product 3 -> 0x100, 0x104, 0x108, 0x100, 0x104 (repeat from base).
- Negative stride / wrap: ADDR_WIDTH=32, base=0x4, d0 len=3 stride=-8 -> 0x4, 0xFFFFFFFC, 0xFFFFFFF4.
- clear_i asserted together with a handshake on the 2nd address -> next cycle addr_valid_o=0, state IDLE, flags=0; a subsequent start_i restarts from base. start_i pulsed in RUN -> ignored, sequence unchanged.
